// File: rtl/soc_addr_map_pkg.sv
// Shared types, field encodings and the reset-time SoC address map for the
// runtime-programmable address decoder.
package soc_addr_map_pkg;

  localparam int unsigned AddrW        = 64;
  localparam int unsigned DefNumRules  = 11;
  localparam int unsigned DefNumSlaves = 11;
  localparam int unsigned SlaveW       = $clog2(DefNumSlaves);
  localparam int unsigned AttrW        = 4;
  localparam int unsigned CfgDataW     = 64;
  localparam int unsigned CntW         = 16;

  typedef struct packed {
    logic cached;
    logic exec;
    logic idempotent;
    logic shared;
  } attr_t;

  typedef struct packed {
    logic [AddrW-1:0]  base;
    logic [AddrW-1:0]  len;
    logic [SlaveW-1:0] slave;
    attr_t             attr;
    logic              en;
  } rule_t;

  typedef rule_t [DefNumRules-1:0] rule_tbl_t;

  typedef enum logic [1:0] {
    FieldBase = 2'd0,
    FieldLen  = 2'd1,
    FieldCtrl = 2'd2,
    FieldRsvd = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StSwap  = 2'd2
  } commit_state_e;

  // Control word layout: {attr, slave, en}, en in bit 0
  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlSlaveLsb = 1;
  localparam int unsigned CtrlAttrLsb  = CtrlSlaveLsb + SlaveW;
  localparam int unsigned CtrlW        = CtrlAttrLsb + AttrW;

  localparam attr_t AttrNone = '{cached: 1'b0, exec: 1'b0, idempotent: 1'b0, shared: 1'b0};
  localparam attr_t AttrExec = '{cached: 1'b0, exec: 1'b1, idempotent: 1'b0, shared: 1'b0};
  localparam attr_t AttrDram = '{cached: 1'b1, exec: 1'b1, idempotent: 1'b0, shared: 1'b1};

  function automatic rule_t mk_rule(input logic [AddrW-1:0] base, input logic [AddrW-1:0] len,
                                    input int unsigned slave, input attr_t attr);
    rule_t r;
    r.base  = base;
    r.len   = len;
    r.slave = SlaveW'(slave);
    r.attr  = attr;
    r.en    = 1'b1;
    return r;
  endfunction

  function automatic logic [CtrlW-1:0] pack_ctrl(input rule_t r);
    return {r.attr, r.slave, r.en};
  endfunction

  function automatic rule_tbl_t default_rules();
    rule_tbl_t t;
    t[0]  = mk_rule(64'h0000_0000_0000_0000, 64'h0000_0000_0000_1000, 0,  AttrExec); // debug
    t[1]  = mk_rule(64'h0000_0000_8000_0000, 64'h0000_0000_4000_0000, 1,  AttrDram); // DRAM
    t[2]  = mk_rule(64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 2,  AttrExec); // boot ROM
    t[3]  = mk_rule(64'h0000_0000_0200_0000, 64'h0000_0000_000C_0000, 3,  AttrNone); // CLINT
    t[4]  = mk_rule(64'h0000_0000_0C00_0000, 64'h0000_0000_0400_0000, 4,  AttrNone); // PLIC
    t[5]  = mk_rule(64'h0000_0000_1000_0000, 64'h0000_0000_0000_1000, 5,  AttrNone); // UART
    t[6]  = mk_rule(64'h0000_0000_1000_1000, 64'h0000_0000_0000_1000, 6,  AttrNone); // GPIO
    t[7]  = mk_rule(64'h0000_0000_1000_2000, 64'h0000_0000_0000_1000, 7,  AttrNone); // SPI
    t[8]  = mk_rule(64'h0000_0000_1000_3000, 64'h0000_0000_0000_1000, 8,  AttrNone); // timer
    t[9]  = mk_rule(64'h0000_0000_1000_4000, 64'h0000_0000_0000_1000, 9,  AttrNone); // I2C
    t[10] = mk_rule(64'h0000_0000_2000_0000, 64'h0000_0000_1000_0000, 10, AttrNone); // ethernet
    return t;
  endfunction

  localparam rule_tbl_t DefaultRules = default_rules();

endpackage

// File: rtl/soc_addr_map_unit_if.sv
// Lookup, configuration and control signal bundle of the address map unit.
interface soc_addr_map_unit_if #(
  parameter int unsigned NumRules  = 11,
  parameter int unsigned NumSlaves = 11,
  parameter int unsigned AddrWidth = 64
) ();
  import soc_addr_map_pkg::*;

  localparam int unsigned IdxW = $clog2(NumRules);
  localparam int unsigned SlvW = $clog2(NumSlaves);

  logic                 lk_valid_i;
  logic                 lk_ready_o;
  logic [AddrWidth-1:0] lk_addr_i;
  logic                 lk_valid_o;
  logic                 lk_ready_i;
  logic [SlvW-1:0]      lk_slave_o;
  attr_t                lk_attr_o;
  logic                 lk_decerr_o;

  logic                 cfg_req_i;
  logic                 cfg_we_i;
  logic [IdxW-1:0]      cfg_idx_i;
  logic [1:0]           cfg_field_i;
  logic [CfgDataW-1:0]  cfg_wdata_i;
  logic                 cfg_gnt_o;
  logic                 cfg_rvalid_o;
  logic [CfgDataW-1:0]  cfg_rdata_o;
  logic                 cfg_err_o;

  logic                 commit_i;
  logic                 lock_i;
  logic                 locked_o;
  logic                 busy_o;
  logic [CntW-1:0]      decerr_cnt_o;

  modport slave (
    input  lk_valid_i, lk_addr_i, lk_ready_i,
    input  cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
    input  commit_i, lock_i,
    output lk_ready_o, lk_valid_o, lk_slave_o, lk_attr_o, lk_decerr_o,
    output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    output locked_o, busy_o, decerr_cnt_o
  );

  modport master (
    output lk_valid_i, lk_addr_i, lk_ready_i,
    output cfg_req_i, cfg_we_i, cfg_idx_i, cfg_field_i, cfg_wdata_i,
    output commit_i, lock_i,
    input  lk_ready_o, lk_valid_o, lk_slave_o, lk_attr_o, lk_decerr_o,
    input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o,
    input  locked_o, busy_o, decerr_cnt_o
  );

endinterface

// File: rtl/soc_addr_map_match.sv
// Single-rule range comparator; the offset form stays correct at the top of
// the address space where base + len would wrap.
module soc_addr_map_match
  import soc_addr_map_pkg::*;
#(
  parameter int unsigned AddrWidth = AddrW
) (
  input  logic [AddrWidth-1:0] addr,
  input  rule_t                rule,
  output logic                 hit_c
);

  logic [AddrWidth-1:0] base;
  logic [AddrWidth-1:0] len;
  logic [AddrWidth-1:0] offset;

  assign base   = AddrWidth'(rule.base);
  assign len    = AddrWidth'(rule.len);
  assign offset = addr - base;
  assign hit_c  = rule.en && (len != '0) && (addr >= base) && (offset < len);

endmodule

// File: rtl/soc_addr_map_unit.sv
// Two-bank programmable address decoder with a 2-stage valid/ready lookup
// pipeline, shadow-bank configuration port, atomic commit and sticky lock.
module soc_addr_map_unit
  import soc_addr_map_pkg::*;
#(
  parameter int unsigned          NumRules  = DefNumRules,
  parameter int unsigned          NumSlaves = DefNumSlaves,
  parameter int unsigned          AddrWidth = AddrW,
  parameter rule_t [NumRules-1:0] RstRules  = DefaultRules
) (
  input logic                clk_i,
  input logic                rst_ni,
  soc_addr_map_unit_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NumRules);
  localparam int unsigned SlvW = $clog2(NumSlaves);

  rule_t [NumRules-1:0] shadow_q;
  rule_t [NumRules-1:0] active_q;
  commit_state_e        state_q;
  logic                 locked_q;

  logic                 s1_valid_q;
  logic [NumRules-1:0]  s1_match_q;
  logic                 s2_valid_q;
  logic [SlvW-1:0]      s2_slave_q;
  attr_t                s2_attr_q;
  logic                 s2_decerr_q;
  logic [CntW-1:0]      decerr_cnt_q;

  logic                 cfg_rvalid_q;
  logic                 cfg_err_q;
  logic [CfgDataW-1:0]  cfg_rdata_q;

  logic [NumRules-1:0]  hit_c;
  logic                 s1_ready;
  logic                 s2_ready;
  logic                 lk_ready;
  logic                 lk_accept;
  logic                 out_fire;
  logic                 win_hit;
  logic [IdxW-1:0]      win_idx;

  // Stage-1 comparators always look at the active bank
  for (genvar g = 0; g < NumRules; g++) begin : g_match
    soc_addr_map_match #(.AddrWidth(AddrWidth)) u_match (
      .addr  (bus.lk_addr_i),
      .rule  (active_q[g]),
      .hit_c (hit_c[g])
    );
  end

  assign s2_ready  = !s2_valid_q || bus.lk_ready_i;
  assign s1_ready  = !s1_valid_q || s2_ready;
  assign lk_ready  = (state_q == StIdle) && s1_ready;
  assign lk_accept = bus.lk_valid_i && lk_ready;
  assign out_fire  = s2_valid_q && bus.lk_ready_i;

  // Lowest index wins among matching rules
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (s1_match_q[i]) begin
        win_hit = 1'b1;
        win_idx = IdxW'(i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_lookup
    if (!rst_ni) begin
      s1_valid_q   <= 1'b0;
      s1_match_q   <= '0;
      s2_valid_q   <= 1'b0;
      s2_slave_q   <= '0;
      s2_attr_q    <= AttrNone;
      s2_decerr_q  <= 1'b0;
      decerr_cnt_q <= '0;
    end else begin
      if (s1_ready) begin
        s1_valid_q <= lk_accept;
        s1_match_q <= lk_accept ? hit_c : '0;
      end
      if (s2_ready) begin
        s2_valid_q  <= s1_valid_q;
        s2_decerr_q <= s1_valid_q && !win_hit;
        s2_slave_q  <= win_hit ? SlvW'(active_q[win_idx].slave) : '0;
        s2_attr_q   <= win_hit ? active_q[win_idx].attr : AttrNone;
      end
      if (out_fire && s2_decerr_q && (decerr_cnt_q != {CntW{1'b1}})) begin
        decerr_cnt_q <= decerr_cnt_q + CntW'(1);
      end
    end
  end

  // Configuration access decode
  logic                cfg_gnt;
  logic                idx_ok;
  logic                slave_ok;
  logic                cfg_err_c;
  logic                wr_en;
  logic [IdxW-1:0]     idx_safe;
  logic [SlaveW-1:0]   wr_slave;
  rule_t               rd_rule;
  logic [CfgDataW-1:0] rdata_c;

  assign cfg_gnt   = bus.cfg_req_i && (state_q == StIdle);
  assign idx_ok    = 32'(bus.cfg_idx_i) < NumRules;
  assign idx_safe  = idx_ok ? bus.cfg_idx_i : '0;
  assign wr_slave  = bus.cfg_wdata_i[CtrlSlaveLsb +: SlaveW];
  assign slave_ok  = 32'(wr_slave) < NumSlaves;
  assign cfg_err_c = !idx_ok || (bus.cfg_field_i == FieldRsvd) ||
                     (bus.cfg_we_i && (locked_q ||
                      ((bus.cfg_field_i == FieldCtrl) && !slave_ok)));
  assign wr_en     = cfg_gnt && bus.cfg_we_i && !cfg_err_c;
  assign rd_rule   = shadow_q[idx_safe];

  always_comb begin
    rdata_c = '0;
    case (bus.cfg_field_i)
      FieldBase: rdata_c = CfgDataW'(rd_rule.base);
      FieldLen:  rdata_c = CfgDataW'(rd_rule.len);
      FieldCtrl: rdata_c = CfgDataW'(pack_ctrl(rd_rule));
      default:   rdata_c = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_tables
    if (!rst_ni) begin
      shadow_q <= RstRules;
      active_q <= RstRules;
    end else begin
      if (wr_en) begin
        case (bus.cfg_field_i)
          FieldBase: shadow_q[idx_safe].base <= AddrW'(bus.cfg_wdata_i);
          FieldLen:  shadow_q[idx_safe].len  <= AddrW'(bus.cfg_wdata_i);
          FieldCtrl: begin
            shadow_q[idx_safe].en    <= bus.cfg_wdata_i[CtrlEnBit];
            shadow_q[idx_safe].slave <= wr_slave;
            shadow_q[idx_safe].attr  <= attr_t'(bus.cfg_wdata_i[CtrlAttrLsb +: AttrW]);
          end
          default: ;
        endcase
      end
      if (state_q == StSwap) begin
        active_q <= shadow_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : p_cfg_rsp
    if (!rst_ni) begin
      cfg_rvalid_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      cfg_rdata_q  <= '0;
    end else begin
      cfg_rvalid_q <= cfg_gnt;
      cfg_err_q    <= cfg_gnt && cfg_err_c;
      cfg_rdata_q  <= (cfg_gnt && !bus.cfg_we_i && !cfg_err_c) ? rdata_c : '0;
    end
  end

  // Commit FSM: drain in-flight lookups, then swap banks in one cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin : p_commit
    if (!rst_ni) begin
      state_q  <= StIdle;
      locked_q <= 1'b0;
    end else begin
      if (bus.lock_i) begin
        locked_q <= 1'b1;
      end
      case (state_q)
        StIdle:  if (bus.commit_i && !locked_q) state_q <= StDrain;
        StDrain: if (!s1_valid_q && !s2_valid_q) state_q <= StSwap;
        StSwap:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.lk_ready_o   = lk_ready;
  assign bus.lk_valid_o   = s2_valid_q;
  assign bus.lk_slave_o   = s2_slave_q;
  assign bus.lk_attr_o    = s2_attr_q;
  assign bus.lk_decerr_o  = s2_decerr_q;
  assign bus.cfg_gnt_o    = cfg_gnt;
  assign bus.cfg_rvalid_o = cfg_rvalid_q;
  assign bus.cfg_rdata_o  = cfg_rdata_q;
  assign bus.cfg_err_o    = cfg_err_q;
  assign bus.locked_o     = locked_q;
  assign bus.busy_o       = (state_q != StIdle);
  assign bus.decerr_cnt_o = decerr_cnt_q;

endmodule
